// File: rtl/anti_theft_timer_if.sv
// anti_theft_timer_if: groups the command, programming and status signals of
// the anti-theft countdown timer.
//   master: drives start_timer/interval and the table write port, observes expired/busy/time_left
//   slave : the timer itself
interface anti_theft_timer_if;
  logic       start_timer;
  logic [1:0] interval;
  logic       prog_we;
  logic [1:0] prog_sel;
  logic [3:0] prog_value;
  logic       expired;
  logic       busy;
  logic [3:0] time_left;

  modport master (
    output start_timer, interval, prog_we, prog_sel, prog_value,
    input  expired, busy, time_left
  );

  modport slave (
    input  start_timer, interval, prog_we, prog_sel, prog_value,
    output expired, busy, time_left
  );
endinterface

// File: rtl/anti_theft_timer.sv
// anti_theft_timer: programmable seconds countdown (arm delay / driver / passenger / alarm-on).
// Latency: expired pulses one cycle after edge start+N*TICK_CYCLES (N=0: after edge start+1).
// Backpressure: none; start_timer always accepted and restarts any running countdown.
//
// Ports:
//   clk, reset          - single rising-edge clock, synchronous active-high reset
//   bus (slave modport) - start_timer/interval command, prog_we/prog_sel/prog_value
//                         table write, expired pulse, busy/time_left status
// Optional feature: define ANTI_THEFT_TIMER_STATUS_EN to drive busy/time_left;
// otherwise both outputs are tied to 0 and expired timing is unchanged.
module anti_theft_timer #(
  parameter int         TICK_CYCLES   = 50_000_000,
  parameter logic [3:0] DEF_ARM_DELAY = 4'd6,
  parameter logic [3:0] DEF_DRIVER    = 4'd8,
  parameter logic [3:0] DEF_PASS      = 4'd15,
  parameter logic [3:0] DEF_ALARM_ON  = 4'd10
) (
  input logic              clk,
  input logic              reset,
  anti_theft_timer_if.slave bus
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_CYCLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    sec_q, sec_d;
  logic          exp_q, exp_d;
  logic [3:0]    time_tbl [4];

  // Table write port. The countdown load below reads the pre-edge contents,
  // so a same-edge write to the selected slot only affects later starts.
  always_ff @(posedge clk) begin
    if (reset) begin
      time_tbl[0] <= DEF_ARM_DELAY;
      time_tbl[1] <= DEF_DRIVER;
      time_tbl[2] <= DEF_PASS;
      time_tbl[3] <= DEF_ALARM_ON;
    end else if (bus.prog_we) begin
      time_tbl[bus.prog_sel] <= bus.prog_value;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pre_q   <= '0;
      sec_q   <= '0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      sec_q   <= sec_d;
      exp_q   <= exp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    sec_d   = sec_q;
    exp_d   = 1'b0;
    // A start always wins, including over a terminal tick of the old run,
    // so an aborted run never produces a pulse.
    if (bus.start_timer) begin
      state_d = RUN;
      sec_d   = time_tbl[bus.interval];
      pre_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          pre_d = '0;
        end
        RUN: begin
          if (sec_q == 4'd0) begin
            // Zero-length interval: finish on the first edge after the start.
            state_d = IDLE;
            exp_d   = 1'b1;
            pre_d   = '0;
          end else if (pre_q == PRE_MAX) begin
            pre_d = '0;
            sec_d = sec_q - 4'd1;
            if (sec_q == 4'd1) begin
              state_d = IDLE;
              exp_d   = 1'b1;
            end
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          pre_d   = '0;
        end
      endcase
    end
  end

  assign bus.expired = exp_q;

`ifdef ANTI_THEFT_TIMER_STATUS_EN
  // state_q is a flop, so busy is a registered status bit.
  assign bus.busy      = (state_q == RUN);
  assign bus.time_left = (state_q == RUN) ? sec_q : 4'd0;
`else
  assign bus.busy      = 1'b0;
  assign bus.time_left = 4'd0;
`endif

endmodule
